// File: rtl/ads127l1x_tdm_deserializer_v2_pkg.sv
// Shared types and constants for the ADS127L1x TDM deserializer:
// the FSM state encoding, legal-parameter limits and the bits-per-lane helper.
package ads127l1x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned MAX_LANES       = 8;
  localparam int unsigned CHANNELS_L14    = 4;
  localparam int unsigned CHANNELS_L18    = 8;
  localparam int unsigned MIN_PACKET_BITS = 16;
  localparam int unsigned MAX_PACKET_BITS = 40;
  localparam int unsigned PACKET_STEP     = 8;
  localparam int unsigned MAX_FRAME_DCLKS = 65535;

  function automatic bit lane_count_legal(input int unsigned n);
    return (n == 1) || (n == 2) || (n == 4) || (n == MAX_LANES);
  endfunction

  function automatic bit channel_count_legal(input int unsigned n);
    return (n == CHANNELS_L14) || (n == CHANNELS_L18);
  endfunction

  function automatic bit packet_bits_legal(input int unsigned b);
    return (b >= MIN_PACKET_BITS) && (b <= MAX_PACKET_BITS) && ((b % PACKET_STEP) == 0);
  endfunction

  // Bits each DOUT lane carries per frame.
  function automatic int unsigned calc_bpl(input int unsigned channels,
                                           input int unsigned lanes,
                                           input int unsigned packet_bits);
    return (channels / lanes) * packet_bits;
  endfunction

endpackage

// File: rtl/ads127l1x_tdm_deserializer_v2_if.sv
// ADC-side and result signals of the deserializer; master = ADC/consumer side,
// slave = the deserializer itself.
interface ads127l1x_tdm_deserializer_v2_if #(
  parameter int unsigned LANE_COUNT      = 4,
  parameter int unsigned CHANNEL_COUNT   = 8,
  parameter int unsigned BITS_PER_PACKET = 24
);

  logic                                       ADC_FSYNC;
  logic [LANE_COUNT-1:0]                      ADC_DOUT;
  logic                                       clear_errors;
  logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0]   ch_packets;
  logic                                       data_ready;
  logic [15:0]                                frame_count;
  logic                                       resync_error;
  logic                                       frame_len_error;

  modport master (
    output ADC_FSYNC, ADC_DOUT, clear_errors,
    input  ch_packets, data_ready, frame_count, resync_error, frame_len_error
  );

  modport slave (
    input  ADC_FSYNC, ADC_DOUT, clear_errors,
    output ch_packets, data_ready, frame_count, resync_error, frame_len_error
  );

endinterface

// File: rtl/ads127l1x_tdm_deserializer_v2_lane_shifter.sv
// One DOUT lane: MSB-first shift register, earliest bit ends up at dout[BPL-1].
module ads127l1x_lane_shifter #(
  parameter int unsigned BPL = 48
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shift_en,
  input  logic           din,
  output logic [BPL-1:0] dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (shift_en) begin
      dout <= {dout[BPL-2:0], din};
    end
  end

endmodule

// File: rtl/ads127l1x_tdm_deserializer_v2.sv
// ADS127L1x TDM DOUT deserializer: FSYNC-framed multi-lane capture into per-channel packets.
// Optional frame-length checker enabled by defining ADS127L1X_FRAME_LEN_CHECK_EN.
module ads127l1x_tdm_deserializer_v2
  import ads127l1x_pkg::*;
#(
  parameter int unsigned LANE_COUNT      = 4,
  parameter int unsigned CHANNEL_COUNT   = 8,
  parameter int unsigned BITS_PER_PACKET = 24,
  parameter int unsigned FRAME_DCLKS     = 0
) (
  input logic                             ADC_DCLK,
  input logic                             reset,
  ads127l1x_tdm_deserializer_v2_if.slave  adc
);

  localparam int unsigned CPL   = CHANNEL_COUNT / LANE_COUNT;
  localparam int unsigned BPL   = calc_bpl(CHANNEL_COUNT, LANE_COUNT, BITS_PER_PACKET);
  localparam int unsigned CNT_W = $clog2(BPL);
  localparam int unsigned PKT_W = CHANNEL_COUNT * BITS_PER_PACKET;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BPL - 1);
  localparam logic [CNT_W-1:0] FIRST_AFTER_MSB = CNT_W'(1);

  if (!lane_count_legal(LANE_COUNT)) begin : g_bad_lane_count
    $error("LANE_COUNT must be 1, 2, 4 or 8");
  end
  if (!channel_count_legal(CHANNEL_COUNT)) begin : g_bad_channel_count
    $error("CHANNEL_COUNT must be 4 or 8");
  end
  if (LANE_COUNT > CHANNEL_COUNT) begin : g_lanes_exceed_channels
    $error("LANE_COUNT must not exceed CHANNEL_COUNT");
  end
  if (!packet_bits_legal(BITS_PER_PACKET)) begin : g_bad_packet_bits
    $error("BITS_PER_PACKET must be 16, 24, 32 or 40");
  end
  if (FRAME_DCLKS > MAX_FRAME_DCLKS) begin : g_bad_frame_dclks
    $error("FRAME_DCLKS must fit in 16 bits");
  end

  state_t                            state;
  logic                              fsync_q;
  logic                              fsync_rise;
  logic [CNT_W-1:0]                  bit_cnt;
  logic                              shift_en;
  logic [LANE_COUNT-1:0][BPL-1:0]    lane_q;
  logic [PKT_W-1:0]                  latched;
  logic [PKT_W-1:0]                  ch_packets_q;
  logic                              data_ready_q;
  logic [15:0]                       frame_count_q;
  logic                              resync_q;

  assign fsync_rise = adc.ADC_FSYNC & ~fsync_q;
  // Any FSYNC rise samples the new MSB, whatever state we are in.
  assign shift_en   = fsync_rise | (state == SHIFT);

  for (genvar n = 0; n < LANE_COUNT; n++) begin : g_lane
    ads127l1x_lane_shifter #(.BPL(BPL)) u_shifter (
      .clk      (ADC_DCLK),
      .reset    (reset),
      .shift_en (shift_en),
      .din      (adc.ADC_DOUT[n]),
      .dout     (lane_q[n])
    );
  end

  // Lane n holds channels n*CPL.. in shift order, earliest packet in the top bits.
  always_comb begin
    latched = '0;
    for (int unsigned n = 0; n < LANE_COUNT; n++) begin
      for (int unsigned j = 0; j < CPL; j++) begin
        latched[(n*CPL + j)*BITS_PER_PACKET +: BITS_PER_PACKET] =
          lane_q[n][(CPL - j)*BITS_PER_PACKET - 1 -: BITS_PER_PACKET];
      end
    end
  end

  always_ff @(posedge ADC_DCLK) begin
    if (reset) begin
      state         <= IDLE;
      fsync_q       <= 1'b0;
      bit_cnt       <= '0;
      ch_packets_q  <= '0;
      data_ready_q  <= 1'b0;
      frame_count_q <= '0;
      resync_q      <= 1'b0;
    end else begin
      fsync_q      <= adc.ADC_FSYNC;
      data_ready_q <= 1'b0;

      if (fsync_rise && (state == SHIFT)) begin
        resync_q <= 1'b1;
      end else if (adc.clear_errors) begin
        resync_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fsync_rise) begin
            bit_cnt <= FIRST_AFTER_MSB;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fsync_rise) begin
            bit_cnt <= FIRST_AFTER_MSB;
          end else if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= LATCH;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          ch_packets_q  <= latched;
          data_ready_q  <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
          if (fsync_rise) begin
            bit_cnt <= FIRST_AFTER_MSB;
            state   <= SHIFT;
          end else begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign adc.ch_packets   = ch_packets_q;
  assign adc.data_ready   = data_ready_q;
  assign adc.frame_count  = frame_count_q;
  assign adc.resync_error = resync_q;

`ifdef ADS127L1X_FRAME_LEN_CHECK_EN
  logic [15:0] len_cnt;
  logic        len_err_q;

  // len_cnt stays 0 until the first FSYNC rise, which leaves that rise unchecked.
  always_ff @(posedge ADC_DCLK) begin
    if (reset) begin
      len_cnt   <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (fsync_rise) begin
        len_cnt <= 16'd1;
      end else if ((len_cnt != '0) && (len_cnt != '1)) begin
        len_cnt <= len_cnt + 16'd1;
      end

      if (fsync_rise && (len_cnt != '0) && (FRAME_DCLKS != 0) &&
          (len_cnt != 16'(FRAME_DCLKS))) begin
        len_err_q <= 1'b1;
      end else if (adc.clear_errors) begin
        len_err_q <= 1'b0;
      end
    end
  end

  assign adc.frame_len_error = len_err_q;
`else
  assign adc.frame_len_error = 1'b0;
`endif

endmodule

// File: tb/tb_ads127l1x_tdm_deserializer_v2.sv
// Bench: 4-lane/24-bit and 1-lane/40-bit deserializers driven from a frame table,
// with a scoreboard of expected packets, frame counts and arrival cycles.
module tb_ads127l1x_tdm_deserializer_v2;

`ifdef ADS127L1X_FRAME_LEN_CHECK_EN
  localparam logic LEN_ERR_EXP = 1'b1;
`else
  localparam logic LEN_ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  ads127l1x_tdm_deserializer_v2_if #(.LANE_COUNT(4), .CHANNEL_COUNT(8), .BITS_PER_PACKET(24)) if_a ();
  ads127l1x_tdm_deserializer_v2_if #(.LANE_COUNT(1), .CHANNEL_COUNT(8), .BITS_PER_PACKET(40)) if_b ();

  ads127l1x_tdm_deserializer_v2 #(
    .LANE_COUNT(4), .CHANNEL_COUNT(8), .BITS_PER_PACKET(24), .FRAME_DCLKS(64)
  ) dut_a (
    .ADC_DCLK (clk),
    .reset    (rst_a),
    .adc      (if_a)
  );

  ads127l1x_tdm_deserializer_v2 #(
    .LANE_COUNT(1), .CHANNEL_COUNT(8), .BITS_PER_PACKET(40), .FRAME_DCLKS(0)
  ) dut_b (
    .ADC_DCLK (clk),
    .reset    (rst_b),
    .adc      (if_b)
  );

  typedef struct {
    logic [319:0] pk;
    logic [15:0]  cnt;
    int unsigned  due;
  } exp_t;

  typedef struct {
    logic [7:0][23:0] ch;
    int unsigned      gap;
    logic [15:0]      cnt;
  } vec_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (if_a.data_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_packets", 320'(if_a.ch_packets), e.pk);
        check("a_frame_count", 320'(if_a.frame_count), 320'(e.cnt));
        check("a_ready_cycle", 320'(cyc), 320'(e.due));
      end
    end
    if (if_b.data_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_packets", 320'(if_b.ch_packets), e.pk);
        check("b_frame_count", 320'(if_b.frame_count), 320'(e.cnt));
        check("b_ready_cycle", 320'(cyc), 320'(e.due));
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    if_a.ADC_FSYNC = 1'b0;
    if_a.ADC_DOUT  = '0;
    if_b.ADC_FSYNC = 1'b0;
    if_b.ADC_DOUT  = '0;
    repeat (n) tick();
  endtask

  // Lane n sends channels 2n then 2n+1, MSB first; FSYNC is high for 4 DCLKs.
  task automatic drive_a(input logic [191:0] pk, input bit push, input int unsigned nbits,
                         input logic [15:0] cnt);
    for (int unsigned k = 0; k < nbits; k++) begin
      if_a.ADC_FSYNC = (k < 4);
      for (int unsigned n = 0; n < 4; n++)
        if_a.ADC_DOUT[n] = pk[(n*2 + k/24)*24 + 23 - (k % 24)];
      if (push && (k == 0))
        q_a.push_back('{pk: 320'(pk), cnt: cnt, due: cyc + 1 + 48});
      tick();
    end
    if_a.ADC_FSYNC = 1'b0;
    if_a.ADC_DOUT  = '0;
  endtask

  task automatic drive_b(input logic [319:0] pk, input logic [15:0] cnt);
    for (int unsigned k = 0; k < 320; k++) begin
      if_b.ADC_FSYNC  = (k < 4);
      if_b.ADC_DOUT[0] = pk[(k/40)*40 + 39 - (k % 40)];
      if (k == 0)
        q_b.push_back('{pk: pk, cnt: cnt, due: cyc + 1 + 320});
      tick();
    end
    if_b.ADC_FSYNC = 1'b0;
    if_b.ADC_DOUT  = '0;
  endtask

  task automatic check_reset_a();
    check("a_rst_packets", 320'(if_a.ch_packets), '0);
    check("a_rst_ready", 320'(if_a.data_ready), '0);
    check("a_rst_frame_count", 320'(if_a.frame_count), '0);
    check("a_rst_resync", 320'(if_a.resync_error), '0);
    check("a_rst_len_err", 320'(if_a.frame_len_error), '0);
  endtask

  initial begin
    vec_t         tbl[4];
    logic [191:0] pk;
    logic [319:0] pkb;

    tbl[0] = '{ch: {24'h000008, 24'h000007, 24'h000006, 24'h000005,
                    24'h000004, 24'h000003, 24'h000002, 24'h000001}, gap: 5, cnt: 16'd1};
    tbl[1] = '{ch: {24'hA5A5A5, 24'h5A5A5A, 24'hFFFFFF, 24'h000000,
                    24'h800000, 24'h000001, 24'h123456, 24'hFEDCBA}, gap: 0, cnt: 16'd2};
    tbl[2] = '{ch: {24'hC3C3C3, 24'h3C3C3C, 24'h0F0F0F, 24'hF0F0F0,
                    24'hAAAAAA, 24'h555555, 24'h7FFFFF, 24'h800001}, gap: 2, cnt: 16'd3};
    tbl[3] = '{ch: {24'h111111, 24'h222222, 24'h333333, 24'h444444,
                    24'h555555, 24'h666666, 24'h777777, 24'h888888}, gap: 6, cnt: 16'd4};

    if_a.clear_errors = 1'b0;
    if_b.clear_errors = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(3);
    check_reset_a();
    check("b_rst_packets", 320'(if_b.ch_packets), '0);
    check("b_rst_ready", 320'(if_b.data_ready), '0);
    check("b_rst_frame_count", 320'(if_b.frame_count), '0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(2);

    // Frame table; gap 0 puts the next FSYNC rise on the LATCH cycle.
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 8; c++) pk[c*24 +: 24] = tbl[i].ch[c];
      drive_a(pk, 1'b1, 48, tbl[i].cnt);
      idle(tbl[i].gap);
    end
    check("a_resync_clean", 320'(if_a.resync_error), '0);

    // FSYNC re-rises at bit 10: partial frame dropped, next one latched.
    drive_a({8{24'hBADBAD}}, 1'b0, 10, 16'd0);
    for (int c = 0; c < 8; c++) pk[c*24 +: 24] = 24'h0C0000 + 24'(c * 24'h010101);
    drive_a(pk, 1'b1, 48, 16'd5);
    check("a_resync_set", 320'(if_a.resync_error), 320'(1));
    idle(3);
    check("a_resync_drained", 320'(q_a.size()), '0);
    if_a.clear_errors = 1'b1;
    tick();
    if_a.clear_errors = 1'b0;
    check("a_resync_cleared", 320'(if_a.resync_error), '0);

    // Reset lands at bit 20 of a frame.
    drive_a({8{24'hDEAD00}}, 1'b0, 20, 16'd0);
    rst_a = 1'b1;
    idle(2);
    check_reset_a();
    check("a_reset_drained", 320'(q_a.size()), '0);
    rst_a = 1'b0;
    idle(1);

    // FSYNC periods 64 then 63 against FRAME_DCLKS = 64.
    for (int c = 0; c < 8; c++) pk[c*24 +: 24] = 24'h900000 | 24'(c);
    drive_a(pk, 1'b1, 48, 16'd1);
    idle(16);
    for (int c = 0; c < 8; c++) pk[c*24 +: 24] = 24'h0000A0 | 24'(c << 12);
    drive_a(pk, 1'b1, 48, 16'd2);
    check("a_len_err_period64", 320'(if_a.frame_len_error), '0);
    idle(15);
    for (int c = 0; c < 8; c++) pk[c*24 +: 24] = ~(24'h000100 << c);
    drive_a(pk, 1'b1, 48, 16'd3);
    check("a_len_err_period63", 320'(if_a.frame_len_error), 320'(LEN_ERR_EXP));
    idle(4);
    if_a.clear_errors = 1'b1;
    tick();
    if_a.clear_errors = 1'b0;
    check("a_len_err_cleared", 320'(if_a.frame_len_error), '0);

    // Single lane, 40-bit packets, back-to-back frames.
    for (int c = 0; c < 8; c++) pkb[c*40 +: 40] = {4'h9, 4'(c), 32'h0F1E2D3C + 32'(c)};
    drive_b(pkb, 16'd1);
    for (int c = 0; c < 8; c++) pkb[c*40 +: 40] = {8'(8'h80 >> c), 32'hFFFF0000 ^ 32'(c)};
    drive_b(pkb, 16'd2);
    idle(4);

    check("a_all_frames_seen", 320'(q_a.size()), '0);
    check("b_all_frames_seen", 320'(q_b.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
